rtc_time_counter: RTL and testbench
===================================

# rtc_time_counter

Parametrised time-of-day counter chaining seconds, minutes and hours in one block. It is the successor to the standalone hour stage and replaces the separate seconds/minutes/hours chain in the clock top level. On top of the old stage it adds configurable moduli, up/down counting, a validated parallel load, a run/pause control and an optional alarm comparator. A one-pulse-per-second tick from the existing prescaler drives it.

## Interface
Parameters:
- SEC_MOD, 60: seconds modulus (2..256)
- MIN_MOD, 60: minutes modulus (2..256)
- HOUR_MOD, 24: hours modulus (2..256); 12 or 16 are also legal
- SW, MW, HW: derived, $clog2 of the matching modulus; not for override

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- tick_in  in  1  one-cycle pulse, one per second
- run  in  1  1 = count on tick_in; 0 = ticks ignored
- dir  in  1  0 = count up; 1 = count down
- load_valid  in  1  request to load the time fields
- load_sec / load_min / load_hour  in  SW / MW / HW  load values
- load_err  out  1  one-cycle pulse: the load was rejected
- alarm_set  in  1  capture the alarm compare fields
- alarm_sec / alarm_min / alarm_hour  in  SW / MW / HW  alarm compare values
- alarm_ack  in  1  clears alarm_out
- seconds / minutes / hours  out  SW / MW / HW  current time, registered
- sec_wrap / min_wrap / day_tick  out  1  one-cycle pulses on carry/borrow out of each stage
- alarm_out  out  1  level: the alarm has fired and is not yet acknowledged

## Operation
- All outputs reset to 0. Alarm registers reset to 0 and disarmed.
- A step happens on a cycle where tick_in & run & !load_valid.
- Up step:
  - seconds increments.
  - At SEC_MOD-1, seconds goes to 0, sec_wrap pulses and minutes steps.
  - Minutes and hours cascade the same way, with min_wrap and day_tick.
- Down step:
  - seconds decrements.
  - At 0, seconds goes to SEC_MOD-1, sec_wrap pulses and minutes borrows.
  - Minutes and hours cascade the same way.
  - 00:00:00 down goes to HOUR_MOD-1:MIN_MOD-1:SEC_MOD-1, with all three pulses.
- Load:
  - load_valid is sampled every cycle. There is no ready signal; a load always completes in one cycle.
  - If every field is below its modulus, all three counters take the load values at that edge.
  - Otherwise no field changes and load_err pulses the next cycle.
  - Load has priority over the tick. A tick in the same cycle is dropped, not deferred.
- Wrap pulses: at most one cycle wide. Never asserted on a load. Never asserted when run=0.
- dir is sampled only on step cycles. Changing dir mid-chain has no side effect.
- Counters are never allowed to hold a value at or above their modulus.
- Reset mid-operation: all state clears immediately (asynchronous). The first possible step is the first tick_in after reset deasserts.

## Timing
- Latency: tick_in high at edge N means updated fields and any wrap pulse are visible after edge N. Zero added cycles; all outputs come from flops.
- load_err: registered, high for the one cycle after the rejected edge.
- Alarm fire: alarm_out rises at the same edge as the step that produces a time equal to the alarm fields.
- Alarm hold: alarm_out stays high until alarm_ack is sampled high.
- Ack vs. fire: if ack and a new match occur at the same edge, alarm_out stays 1 (fire wins).
- A load that writes a time equal to the alarm fields does not fire.
- alarm_set captures the fields at the edge and arms the alarm. It does not clear alarm_out.

## Configuration
- RTC_ALARM_EN defined:
  - alarm registers, comparator and alarm_out flop are built as described above.
- RTC_ALARM_EN undefined:
  - alarm ports remain on the module (inputs ignored).
  - alarm_out is tied to 0.
  - no alarm flops are synthesised.
- The counting and load behaviour is identical either way.

## Test plan
- Up wrap, defaults: load 23:59:58, two ticks. Expect 23:59:59, then 00:00:00 with sec_wrap, min_wrap and day_tick all high for exactly one cycle.
- Down borrow, HOUR_MOD=12: reset, dir=1, one tick. Expect 11:59:59 with all three pulses. A second tick gives 11:59:58 with no pulses.
- Load checks:
  - load 24:00:00 (defaults): load_err=1 for one cycle, time unchanged.
  - load 12:30:45 with tick_in in the same cycle: time = 12:30:45 and no step.
- Pause: run=0, five ticks, time unchanged. run=1, one tick, seconds +1.
- Alarm (RTC_ALARM_EN):
  - alarm_set 00:01:00, load 00:00:59, tick: alarm_out=1 and holds.
  - alarm_ack clears it.
  - rebuilt without the macro, the same stimulus keeps alarm_out=0.
- Async reset: assert reset between clock edges at 05:06:07. All outputs read 0 before the next edge, and alarm_out=0.

Source files
------------

// File: rtl/rtc_time_counter.sv
// rtc_time_counter: seconds/minutes/hours time-of-day counter.
// Moduli are set by parameters. It counts up or down on a per-second tick,
// accepts a parallel load that is checked before it is applied, and can be
// paused with run.
// Build option: define RTC_ALARM_EN to build the alarm comparator and the
// alarm_out flop. When it is undefined, alarm_out is tied to 0 and the alarm
// inputs are ignored.

// One modulo-MOD counter stage. cnt_nxt and carry are combinational
// look-aheads. The parent uses them to register the wrap pulses and to
// compare against the alarm.
module rtc_stage #(
    parameter  int MOD = 60,
    localparam int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         dir,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         carry
);
    localparam logic [W-1:0] MAX = W'(MOD - 1);

    // Compute the next count and the carry/borrow out for a step
    always_comb begin
        cnt_nxt = cnt;
        carry   = 1'b0;
        if (step) begin
            if (dir) begin
                if (cnt == '0) begin
                    cnt_nxt = MAX;
                    carry   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end else begin
                if (cnt == MAX) begin
                    cnt_nxt = '0;
                    carry   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        end
    end

    // Count register: a load replaces the value, otherwise take the stepped value
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        cnt <= '0;
        else if (load_en) cnt <= load_val;
        else              cnt <= cnt_nxt;
    end
endmodule

module rtc_time_counter #(
    parameter  int SEC_MOD  = 60,
    parameter  int MIN_MOD  = 60,
    parameter  int HOUR_MOD = 24,
    localparam int SW = $clog2(SEC_MOD),
    localparam int MW = $clog2(MIN_MOD),
    localparam int HW = $clog2(HOUR_MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick_in,
    input  logic          run,
    input  logic          dir,
    input  logic          load_valid,
    input  logic [SW-1:0] load_sec,
    input  logic [MW-1:0] load_min,
    input  logic [HW-1:0] load_hour,
    output logic          load_err,
    input  logic          alarm_set,
    input  logic [SW-1:0] alarm_sec,
    input  logic [MW-1:0] alarm_min,
    input  logic [HW-1:0] alarm_hour,
    input  logic          alarm_ack,
    output logic [SW-1:0] seconds,
    output logic [MW-1:0] minutes,
    output logic [HW-1:0] hours,
    output logic          sec_wrap,
    output logic          min_wrap,
    output logic          day_tick,
    output logic          alarm_out
);
    localparam logic [SW:0] SEC_LIM  = (SW+1)'(SEC_MOD);
    localparam logic [MW:0] MIN_LIM  = (MW+1)'(MIN_MOD);
    localparam logic [HW:0] HOUR_LIM = (HW+1)'(HOUR_MOD);

    logic          step, load_ok, load_en;
    logic          sec_c, min_c, hour_c;
    logic [SW-1:0] sec_nxt;
    logic [MW-1:0] min_nxt;
    logic [HW-1:0] hour_nxt;

    // A load always wins over a tick. The tick in that cycle is lost.
    assign step    = tick_in & run & ~load_valid;
    assign load_ok = ({1'b0, load_sec}  < SEC_LIM) &
                     ({1'b0, load_min}  < MIN_LIM) &
                     ({1'b0, load_hour} < HOUR_LIM);
    assign load_en = load_valid & load_ok;

    rtc_stage #(.MOD(SEC_MOD)) u_sec (
        .clk(clk), .reset(reset), .step(step), .dir(dir), .load_en(load_en),
        .load_val(load_sec), .cnt(seconds), .cnt_nxt(sec_nxt), .carry(sec_c)
    );
    rtc_stage #(.MOD(MIN_MOD)) u_min (
        .clk(clk), .reset(reset), .step(sec_c), .dir(dir), .load_en(load_en),
        .load_val(load_min), .cnt(minutes), .cnt_nxt(min_nxt), .carry(min_c)
    );
    rtc_stage #(.MOD(HOUR_MOD)) u_hour (
        .clk(clk), .reset(reset), .step(min_c), .dir(dir), .load_en(load_en),
        .load_val(load_hour), .cnt(hours), .cnt_nxt(hour_nxt), .carry(hour_c)
    );

    // Register the carry pulses and the load-reject flag. Each is one cycle wide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_wrap <= 1'b0;
            min_wrap <= 1'b0;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_wrap <= sec_c;
            min_wrap <= min_c;
            day_tick <= hour_c;
            load_err <= load_valid & ~load_ok;
        end
    end

`ifdef RTC_ALARM_EN
    logic [SW-1:0] al_sec;
    logic [MW-1:0] al_min;
    logic [HW-1:0] al_hour;
    logic          armed, fire;

    // Only a step can fire the alarm. A load that lands on the alarm time does not.
    assign fire = step & armed & (sec_nxt == al_sec) &
                  (min_nxt == al_min) & (hour_nxt == al_hour);

    // Capture the alarm time and arm the alarm. The alarm stays armed after it fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            al_sec  <= '0;
            al_min  <= '0;
            al_hour <= '0;
            armed   <= 1'b0;
        end else if (alarm_set) begin
            al_sec  <= alarm_sec;
            al_min  <= alarm_min;
            al_hour <= alarm_hour;
            armed   <= 1'b1;
        end
    end

    // alarm_out level: a new match wins over an ack in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          alarm_out <= 1'b0;
        else if (fire)      alarm_out <= 1'b1;
        else if (alarm_ack) alarm_out <= 1'b0;
    end
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_set, alarm_sec, alarm_min, alarm_hour,
                            alarm_ack, sec_nxt, min_nxt, hour_nxt};
    assign alarm_out    = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter: a default (24h) instance and a 12h
// instance driven with the same stimulus. Expected outputs go into a queue
// when each step is driven and are popped and compared after the edge.
module tb_rtc_time_counter;
`ifdef RTC_ALARM_EN
    localparam bit AL = 1'b1;
`else
    localparam bit AL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in, run, dir, load_valid, alarm_set, alarm_ack;
    logic [5:0] load_sec, load_min, alarm_sec, alarm_min;
    logic [4:0] load_hour, alarm_hour;

    logic [5:0] seconds, minutes;
    logic [4:0] hours;
    logic       load_err, sec_wrap, min_wrap, day_tick, alarm_out;

    logic [5:0] s12, m12;
    logic [3:0] h12;
    logic       le12, sw12, mw12, dt12, ao12;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [21:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rtc_time_counter u (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .dir(dir),
        .load_valid(load_valid), .load_sec(load_sec), .load_min(load_min),
        .load_hour(load_hour), .load_err(load_err), .alarm_set(alarm_set),
        .alarm_sec(alarm_sec), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
        .alarm_ack(alarm_ack), .seconds(seconds), .minutes(minutes),
        .hours(hours), .sec_wrap(sec_wrap), .min_wrap(min_wrap),
        .day_tick(day_tick), .alarm_out(alarm_out)
    );

    rtc_time_counter #(.HOUR_MOD(12)) u12 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .dir(dir),
        .load_valid(load_valid), .load_sec(load_sec), .load_min(load_min),
        .load_hour(load_hour[3:0]), .load_err(le12), .alarm_set(alarm_set),
        .alarm_sec(alarm_sec), .alarm_min(alarm_min),
        .alarm_hour(alarm_hour[3:0]), .alarm_ack(alarm_ack), .seconds(s12),
        .minutes(m12), .hours(h12), .sec_wrap(sw12), .min_wrap(mw12),
        .day_tick(dt12), .alarm_out(ao12)
    );

    function automatic logic [21:0] pk(int h, int m, int s, bit sw, bit mw,
                                       bit dt, bit le, bit ao);
        logic [4:0] hh = 5'(h);
        logic [5:0] mm = 6'(m);
        logic [5:0] ss = 6'(s);
        return {hh, mm, ss, sw, mw, dt, le, ao};
    endfunction

    function automatic logic [21:0] obs();
        return {hours, minutes, seconds, sec_wrap, min_wrap, day_tick,
                load_err, alarm_out};
    endfunction

    task automatic check_pop();
        exp_t e;
        logic [21:0] o;
        e = sb.pop_front();
        o = obs();
        n_assert++;
        assert (o === e.v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
        end
    endtask

    task automatic chk12(string tag, int h, int m, int s, bit p);
        logic [21:0] o, e;
        o = {1'b0, h12, m12, s12, sw12, mw12, dt12, le12, ao12};
        e = pk(h, m, s, p, p, p, 1'b0, 1'b0);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Push the expected result, take one edge, drop the strobes, then compare
    task automatic cyc(string tag, logic [21:0] ev);
        exp_t e;
        e.tag = tag;
        e.v   = ev;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tick_in    = 1'b0;
        load_valid = 1'b0;
        alarm_set  = 1'b0;
        alarm_ack  = 1'b0;
        check_pop();
    endtask

    task automatic set_load(int h, int m, int s);
        load_valid = 1'b1;
        load_hour  = 5'(h);
        load_min   = 6'(m);
        load_sec   = 6'(s);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; tick_in = 0; run = 1; dir = 0; load_valid = 0;
        alarm_set = 0; alarm_ack = 0;
        load_sec = 0; load_min = 0; load_hour = 0;
        alarm_sec = 0; alarm_min = 0; alarm_hour = 0;
        #3;
        e.tag = "reset_state"; e.v = pk(0,0,0,0,0,0,0,0); sb.push_back(e);
        check_pop();
        #9 reset = 1'b0;
        @(posedge clk); #1;

        // Up wrap through the end of the day
        set_load(23, 59, 58);         cyc("load_235958", pk(23,59,58,0,0,0,0,0));
        tick_in = 1;                  cyc("up_235959",   pk(23,59,59,0,0,0,0,0));
        tick_in = 1;                  cyc("up_daywrap",  pk(0,0,0,1,1,1,0,0));
        cyc("pulse_one_cycle", pk(0,0,0,0,0,0,0,0));

        // Rejected loads
        set_load(24, 0, 0);           cyc("load_bad_hour", pk(0,0,0,0,0,0,1,0));
        cyc("load_err_drop", pk(0,0,0,0,0,0,0,0));
        set_load(0, 60, 0);           cyc("load_bad_min",  pk(0,0,0,0,0,0,1,0));
        set_load(0, 0, 60);           cyc("load_bad_sec",  pk(0,0,0,0,0,0,1,0));

        // A load in the same cycle as a tick drops the tick
        set_load(12, 30, 45); tick_in = 1;
        cyc("load_beats_tick", pk(12,30,45,0,0,0,0,0));

        // Pause
        run = 0;
        for (int i = 0; i < 5; i++) begin
            tick_in = 1; cyc("paused_tick", pk(12,30,45,0,0,0,0,0));
        end
        run = 1;
        tick_in = 1;                  cyc("resume_tick", pk(12,30,46,0,0,0,0,0));

        // Minute carry without an hour carry, then a borrow back
        set_load(0, 0, 59);           cyc("load_000059", pk(0,0,59,0,0,0,0,0));
        tick_in = 1;                  cyc("min_carry",   pk(0,1,0,1,0,0,0,0));
        dir = 1; tick_in = 1;         cyc("min_borrow",  pk(0,0,59,1,0,0,0,0));
        dir = 0;

        // Async reset between edges
        set_load(5, 6, 7);            cyc("load_050607", pk(5,6,7,0,0,0,0,0));
        #3 reset = 1'b1;
        #1;
        e.tag = "async_reset"; e.v = pk(0,0,0,0,0,0,0,0); sb.push_back(e);
        check_pop();
        chk12("async_reset_12h", 0, 0, 0, 0);
        #2 reset = 1'b0;
        cyc("post_reset_idle", pk(0,0,0,0,0,0,0,0));

        // Down borrow from zero on both hour moduli
        dir = 1; tick_in = 1;         cyc("down_borrow", pk(23,59,59,1,1,1,0,0));
        chk12("down_borrow_12h", 11, 59, 59, 1);
        tick_in = 1;                  cyc("down_second", pk(23,59,58,0,0,0,0,0));
        chk12("down_second_12h", 11, 59, 58, 0);
        dir = 0;

        // Alarm
        alarm_set = 1; alarm_hour = 0; alarm_min = 1; alarm_sec = 0;
        cyc("alarm_set", pk(23,59,58,0,0,0,0,0));
        set_load(0, 0, 59);           cyc("al_load",     pk(0,0,59,0,0,0,0,0));
        tick_in = 1;                  cyc("al_fire",     pk(0,1,0,1,0,0,0,AL));
        cyc("al_hold", pk(0,1,0,0,0,0,0,AL));
        alarm_ack = 1;                cyc("al_ack",      pk(0,1,0,0,0,0,0,0));
        set_load(0, 0, 59);           cyc("al_reload",   pk(0,0,59,0,0,0,0,0));
        tick_in = 1;                  cyc("al_refire",   pk(0,1,0,1,0,0,0,AL));
        set_load(0, 0, 59);           cyc("al_load_hold", pk(0,0,59,0,0,0,0,AL));
        tick_in = 1; alarm_ack = 1;   cyc("al_fire_wins", pk(0,1,0,1,0,0,0,AL));
        alarm_ack = 1;                cyc("al_ack2",     pk(0,1,0,0,0,0,0,0));
        set_load(0, 1, 0);            cyc("al_load_nofire", pk(0,1,0,0,0,0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
